// File: rtl/csr_timer_bank_pkg.sv
// Shared constants for the CSR timer bank: register offsets, TCFG field
// positions and the masked-write merge used by every writable field.
package csr_timer_bank_pkg;

  localparam logic [1:0] OFF_TCFG  = 2'd0;
  localparam logic [1:0] OFF_TVAL  = 2'd1;
  localparam logic [1:0] OFF_TICLR = 2'd2;
  localparam int         CHAN_STRIDE = 4;

  typedef enum logic [1:0] {
    G_INT_STAT = 2'd0,
    G_INT_EN   = 2'd1,
    G_CNT_LO   = 2'd2,
    G_CNT_HI   = 2'd3
  } glob_reg_e;

  localparam int TCFG_EN        = 0;
  localparam int TCFG_PERIODIC  = 1;
  localparam int TCFG_INITV_LSB = 2;

  function automatic logic [31:0] masked_merge(input logic [31:0] old,
                                               input logic [31:0] wmask,
                                               input logic [31:0] wvalue);
    return (wmask & wvalue) | (~wmask & old);
  endfunction

endpackage

// File: rtl/csr_timer_chan.sv
// One countdown timer channel: TCFG fields, down-counter and pending bit.
// A one-shot channel parks at all-ones after passing zero.
module csr_timer_chan
  import csr_timer_bank_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tcfg_we,
  input  logic        ticlr_we,
  input  logic [31:0] wmask,
  input  logic [31:0] wvalue,
  output logic [31:0] tcfg_rvalue,
  output logic [31:0] tval,
  output logic        pending
);

  logic             en;
  logic             periodic;
  logic [CNT_W-3:0] initv;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      merged;
  logic [CNT_W-1:0] cfg_new;
  logic             at_zero;
  logic             halted;
  logic             clr;
  logic             unused_hi;

  assign tcfg_rvalue = 32'({initv, periodic, en});
  assign merged      = masked_merge(tcfg_rvalue, wmask, wvalue);
  assign cfg_new     = merged[CNT_W-1:0];
  assign unused_hi   = ^merged;
  assign at_zero     = (cnt == {CNT_W{1'b0}});
  assign halted      = (cnt == {CNT_W{1'b1}});
  assign clr         = ticlr_we & wmask[0] & wvalue[0];
  assign tval        = 32'(cnt);

  // TCFG field register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en       <= 1'b0;
      periodic <= 1'b0;
      initv    <= {(CNT_W-2){1'b0}};
    end else if (tcfg_we) begin
      en       <= cfg_new[TCFG_EN];
      periodic <= cfg_new[TCFG_PERIODIC];
      initv    <= cfg_new[CNT_W-1:TCFG_INITV_LSB];
    end
  end

  // Down-counter: an enabling TCFG write reloads ahead of normal counting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= {CNT_W{1'b1}};
    end else if (tcfg_we && cfg_new[TCFG_EN]) begin
      cnt <= {cfg_new[CNT_W-1:TCFG_INITV_LSB], 2'b00};
    end else if (en && !halted) begin
      if (at_zero && periodic) begin
        cnt <= {initv, 2'b00};
      end else begin
        cnt <= cnt - {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Pending flag; a terminal count beats a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
    end else if (en && at_zero) begin
      pending <= 1'b1;
    end else if (clr) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/csr_timer_bank.sv
// Multi-channel CSR timer bank: address decode, read mux, interrupt enable
// mask and a free-running 64-bit stable counter.
module csr_timer_bank
  import csr_timer_bank_pkg::*;
#(
  parameter int          NUM_TIMERS = 4,
  parameter int          CNT_W      = 32,
  parameter logic [13:0] BASE_ADDR  = 14'h0100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  csr_re,
  input  logic [13:0]           csr_num,
  output logic [31:0]           csr_rvalue,
  input  logic                  csr_we,
  input  logic [31:0]           csr_wmask,
  input  logic [31:0]           csr_wvalue,
  output logic                  hit,
  output logic [NUM_TIMERS-1:0] timer_int,
  output logic                  irq
);

  localparam logic [13:0] G_OFF = 14'(CHAN_STRIDE * NUM_TIMERS);

  logic [13:0]           off;
  logic [NUM_TIMERS-1:0] chan_sel;
  logic [NUM_TIMERS-1:0] tcfg_we;
  logic [NUM_TIMERS-1:0] ticlr_we;
  logic [NUM_TIMERS-1:0] pending;
  logic [NUM_TIMERS-1:0] int_en;
  logic [31:0]           tcfg_rv [NUM_TIMERS];
  logic [31:0]           tval_rv [NUM_TIMERS];
  logic [31:0]           int_en_merged;
  logic                  int_en_we;
  logic [63:0]           stable;
  logic                  unused_ok;

  assign off           = csr_num - BASE_ADDR;
  assign int_en_merged = masked_merge(32'(int_en), csr_wmask, csr_wvalue);
  assign unused_ok     = ^{csr_re, int_en_merged};

  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_chan
    assign chan_sel[i] = (off[13:2] == 12'(i));

    csr_timer_chan #(.CNT_W(CNT_W)) u_chan (
      .clk        (clk),
      .reset      (reset),
      .tcfg_we    (tcfg_we[i]),
      .ticlr_we   (ticlr_we[i]),
      .wmask      (csr_wmask),
      .wvalue     (csr_wvalue),
      .tcfg_rvalue(tcfg_rv[i]),
      .tval       (tval_rv[i]),
      .pending    (pending[i])
    );
  end

  // Address decode, write strobes and read mux
  always_comb begin
    csr_rvalue = 32'd0;
    hit        = 1'b0;
    tcfg_we    = {NUM_TIMERS{1'b0}};
    ticlr_we   = {NUM_TIMERS{1'b0}};
    int_en_we  = 1'b0;
    if (off < G_OFF) begin
      hit = (off[1:0] != 2'd3);
      for (int i = 0; i < NUM_TIMERS; i++) begin
        tcfg_we[i]  = csr_we & chan_sel[i] & (off[1:0] == OFF_TCFG);
        ticlr_we[i] = csr_we & chan_sel[i] & (off[1:0] == OFF_TICLR);
        csr_rvalue  = csr_rvalue
                    | ({32{chan_sel[i] & (off[1:0] == OFF_TCFG)}} & tcfg_rv[i])
                    | ({32{chan_sel[i] & (off[1:0] == OFF_TVAL)}} & tval_rv[i]);
      end
    end else if (off < G_OFF + 14'd4) begin
      hit = 1'b1;
      case (glob_reg_e'(off[1:0]))
        G_INT_STAT: csr_rvalue = 32'(pending);
        G_INT_EN: begin
          csr_rvalue = 32'(int_en);
          int_en_we  = csr_we;
        end
        G_CNT_LO:   csr_rvalue = stable[31:0];
        G_CNT_HI:   csr_rvalue = stable[63:32];
        default:    csr_rvalue = 32'd0;
      endcase
    end else begin
      hit = 1'b0;
    end
  end

  // Interrupt enable mask
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int_en <= {NUM_TIMERS{1'b0}};
    end else if (int_en_we) begin
      int_en <= int_en_merged[NUM_TIMERS-1:0];
    end
  end

  // Free-running stable counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= 64'd0;
    end else begin
      stable <= stable + 64'd1;
    end
  end

  // Both operands are flops, so the interrupt lines change only on clock edges
  assign timer_int = pending & int_en;
  assign irq       = |timer_int;

endmodule

// File: doc/csr_timer_bank.md
Name: csr_timer_bank

Overview:
- Parametrised multi-channel successor to the single CSR timer (TCFG/TVAL/TICLR) in the CSR file.
- Provides NUM_TIMERS independent countdown timers, each one-shot or periodic, with per-channel pending bits and a global interrupt-enable mask.
- Also provides a free-running 64-bit stable counter.
- Sits beside csr_reg on the same masked CSR access bus; its interrupt output feeds an ESTAT.IS input.

Parameters:
- NUM_TIMERS, 4, number of timer channels (1..8).
- CNT_W, 32, counter width in bits (8..32); the INITV field is CNT_W-2 bits wide.
- BASE_ADDR, 14'h0100, CSR number of channel 0 TCFG.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- csr_re  in  1  read strobe (informational; reads are combinational)
- csr_num  in  14  CSR index
- csr_rvalue  out  32  read data; 0 when the address is unmapped
- csr_we  in  1  write strobe
- csr_wmask  in  32  per-bit write mask
- csr_wvalue  in  32  write data
- hit  out  1  csr_num decodes to this block
- timer_int  out  NUM_TIMERS  per-channel pending AND INT_EN
- irq  out  1  OR of timer_int

Behaviour:
- Address map. Let off = csr_num - BASE_ADDR.
  - Channel i: off 4i = TCFG, 4i+1 = TVAL (read-only), 4i+2 = TICLR (write-1-to-clear, reads 0).
  - Global, with G = 4*NUM_TIMERS: G = INT_STAT (read-only pending bitmap), G+1 = INT_EN (NUM_TIMERS bits, R/W), G+2 = CNT_LO (read-only), G+3 = CNT_HI (read-only).
  - Any other offset: hit=0, read 0, writes ignored.
- Masked write rule for every writable field: new = (wmask & wvalue) | (~wmask & old).
- TCFG layout: [0] EN, [1] PERIODIC, [CNT_W-1:2] INITV. Bits at and above CNT_W read as 0.
- Counter per channel (cnt, CNT_W bits). Priority, highest first:
  - TCFG write whose merged EN=1: cnt <= {INITV_new, 2'b00}.
  - EN=1 and cnt != all-ones:
    - cnt==0 and PERIODIC: cnt <= {INITV, 2'b00}.
    - otherwise: cnt <= cnt-1. A one-shot timer wraps 0 -> all-ones and then halts.
  - Otherwise: hold.
- TCFG write with merged EN=0 leaves cnt unchanged.
- Pending bit per channel:
  - Set in the cycle EN=1 and cnt==0.
  - Cleared by a TICLR write with wmask[0]=1 and wvalue[0]=1.
  - Set and clear in the same cycle: set wins.
  - Pending is not affected by INT_EN; INT_EN only gates timer_int.
- TVAL read returns cnt zero-extended to 32 bits.
- Stable counter: 64 bits, +1 every cycle, wraps silently. Reads are combinational, so CNT_LO and CNT_HI are not atomic with each other.
- Reset (asynchronous, any cycle including mid-count) sets:
  - cnt = all-ones, EN=0, PERIODIC=0, INITV=0, pending=0, INT_EN=0, stable counter=0.
  - Therefore timer_int=0 and irq=0.
- Latency:
  - Writes take effect at the next clock edge.
  - timer_int/irq are registered: they go high one cycle after the cnt==0 cycle.
- Writes to read-only registers (TVAL, INT_STAT, CNT_*) are ignored.

Decomposition:
- Shared package/defines:
  - offset constants OFF_TCFG=0, OFF_TVAL=1, OFF_TICLR=2, channel stride 4, global register offsets;
  - TCFG bit indices EN=0, PERIODIC=1, INITV=[CNT_W-1:2].
- Sub-module csr_timer_chan, instantiated NUM_TIMERS times via generate:
  - contains one channel's TCFG fields, counter and pending bit;
  - inputs: decoded tcfg_we, ticlr_we, wmask, wvalue;
  - outputs: tcfg_rvalue, tval, pending.
- The top level holds decode, INT_EN, the stable counter and the read mux.

Test Plan:
- Reset mid-count: ch0 counting, assert reset -> all TVAL read 32'hFFFFFFFF, timer_int=0, CNT_LO=0.
- One-shot: write ch1 TCFG = 0x11 (INITV=4, EN=1) -> TVAL = 16,15,...,0; pending set at 0; TVAL then 0xFFFFFFFF and holds; INT_EN=0x2 gives irq=1.
- Periodic: ch2 TCFG = 0x0B (INITV=2, PERIODIC=1, EN=1) -> count 8..0, reload 8; pending re-asserts every 9 cycles.
- Clear race: issue TICLR write 0x1 on ch0 in the same cycle cnt==0 -> pending stays 1; a second TICLR one cycle later -> pending 0, irq 0.
- Masked write: TCFG = 0x15, then write wmask=0x2, wvalue=0xFFFF -> TCFG reads 0x17 and cnt is reloaded to 20.
- Decode/params: NUM_TIMERS=2, CNT_W=16 -> TCFG write 0xFFFFFFFF reads 0x0000FFFF; TVAL reads 0xFFFC after the load; offset 12 gives hit=0 and read 0.
